// File: rtl/pad_io_ctrl.sv
// pad_io_ctrl: per-pin pad drive with safe turnaround, synchronised debounced input, edge events and sticky interrupts
module pad_io_ctrl #(
  parameter int NPAD = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W = 4
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic [NPAD-1:0] core_do,
  input  logic [NPAD-1:0] core_oe,
  input  logic [DB_W-1:0] db_limit,
  input  logic [NPAD-1:0] int_en,
  input  logic [NPAD-1:0] int_clr,
  output logic [NPAD-1:0] pad_i,
  output logic [NPAD-1:0] pad_oen,
  input  logic [NPAD-1:0] pad_c,
  output logic [NPAD-1:0] core_di,
  output logic [NPAD-1:0] rise_evt,
  output logic [NPAD-1:0] fall_evt,
  output logic [NPAD-1:0] int_stat,
  output logic            irq
);
  typedef enum logic [1:0] {IN, TURN, OUT} dir_t;
  dir_t            st [NPAD];
  logic [NPAD-1:0] sync [SYNC_STAGES];
  logic [DB_W-1:0] cnt [NPAD];
  logic [NPAD-1:0] s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge pclk) begin
    if (rst) begin
      pad_i    <= '0;
      pad_oen  <= '1;
      core_di  <= '0;
      rise_evt <= '0;
      fall_evt <= '0;
      int_stat <= '0;
      irq      <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      for (int n = 0; n < NPAD; n++) begin
        st[n]  <= IN;
        cnt[n] <= '0;
      end
    end else begin
      pad_i    <= core_do;
      sync[0]  <= pad_c;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      int_stat <= (int_stat & ~int_clr) | ((rise_evt | fall_evt) & int_en);
      irq      <= |int_stat;
      for (int n = 0; n < NPAD; n++) begin
        st[n]       <= core_oe[n] ? (st[n] == IN ? TURN : OUT) : IN;
        pad_oen[n]  <= !(core_oe[n] && st[n] != IN);
        rise_evt[n] <= 1'b0;
        fall_evt[n] <= 1'b0;
        if (s[n] == core_di[n]) begin
          cnt[n] <= '0;
        end else if (cnt[n] >= db_limit) begin
          core_di[n]  <= s[n];
          rise_evt[n] <= s[n];
          fall_evt[n] <= !s[n];
          cnt[n]      <= '0;
        end else begin
          cnt[n] <= cnt[n] + DB_W'(cnt[n] != '1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pad_io_ctrl.sv
// tb_pad_io_ctrl: directed literal checks plus randomized run against a cycle model
module tb_pad_io_ctrl;
  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] core_do = '0, core_oe = '0, int_en = '0, int_clr = '0, pad_c = '0;
  logic [3:0] db_limit = '0;
  logic [7:0] pad_i, pad_oen, core_di, rise_evt, fall_evt, int_stat;
  logic       irq;
  int tests = 0, fails = 0;

  always #5 pclk = ~pclk;

  pad_io_ctrl dut (
    .pclk(pclk), .rst(rst), .core_do(core_do), .core_oe(core_oe), .db_limit(db_limit),
    .int_en(int_en), .int_clr(int_clr), .pad_i(pad_i), .pad_oen(pad_oen), .pad_c(pad_c),
    .core_di(core_di), .rise_evt(rise_evt), .fall_evt(fall_evt), .int_stat(int_stat), .irq(irq)
  );

  logic [7:0] m_pad_i, m_oen, m_di, m_rise, m_fall, m_stat, m_prev_oe, m_s, m_nr, m_nf;
  logic [7:0] m_hist [2];
  logic       m_irq;
  int         m_run [8];

  always @(posedge pclk) begin
    if (rst) begin
      m_pad_i = '0; m_oen = '1; m_di = '0; m_rise = '0; m_fall = '0;
      m_stat = '0; m_irq = 1'b0; m_prev_oe = '0; m_hist[0] = '0; m_hist[1] = '0;
      for (int n = 0; n < 8; n++) m_run[n] = 0;
    end else begin
      m_s = m_hist[1];
      m_nr = '0;
      m_nf = '0;
      for (int n = 0; n < 8; n++) begin
        if (m_s[n] == m_di[n]) m_run[n] = 0;
        else if (m_run[n] >= int'(db_limit)) begin
          m_di[n] = m_s[n];
          m_nr[n] = m_s[n];
          m_nf[n] = !m_s[n];
          m_run[n] = 0;
        end else m_run[n] = (m_run[n] < 15) ? m_run[n] + 1 : 15;
      end
      m_irq = |m_stat;
      m_stat = (m_stat & ~int_clr) | ((m_rise | m_fall) & int_en);
      m_rise = m_nr;
      m_fall = m_nf;
      m_oen = ~(core_oe & m_prev_oe);
      m_prev_oe = core_oe;
      m_hist[1] = m_hist[0];
      m_hist[0] = pad_c;
      m_pad_i = core_do;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    chk("m_pad_i", pad_i, m_pad_i);
    chk("m_pad_oen", pad_oen, m_oen);
    chk("m_core_di", core_di, m_di);
    chk("m_rise", rise_evt, m_rise);
    chk("m_fall", fall_evt, m_fall);
    chk("m_int_stat", int_stat, m_stat);
    chk("m_irq", {7'b0, irq}, {7'b0, m_irq});
  end

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  initial begin
    core_oe = 8'hFF;
    core_do = 8'hA5;
    repeat (3) begin
      step(1);
      chk("rst_oen", pad_oen, 8'hFF);
      chk("rst_pad_i", pad_i, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
    end
    rst = 1'b0;
    step(1);
    chk("rel1_pad_i", pad_i, 8'hA5);
    chk("rel1_oen", pad_oen, 8'hFF);
    step(1);
    chk("rel2_oen", pad_oen, 8'h00);
    core_oe = '0;
    core_do = '0;
    step(2);
    core_oe[0] = 1'b1;
    step(1);
    chk("turn_a", {7'b0, pad_oen[0]}, 8'h01);
    core_oe[0] = 1'b0;
    step(1);
    chk("turn_b", {7'b0, pad_oen[0]}, 8'h01);
    step(1);
    chk("turn_c", {7'b0, pad_oen[0]}, 8'h01);
    core_oe[0] = 1'b1;
    step(1);
    chk("en_1", {7'b0, pad_oen[0]}, 8'h01);
    step(1);
    chk("en_2", {7'b0, pad_oen[0]}, 8'h00);
    core_oe[0] = 1'b0;
    step(1);
    chk("release", {7'b0, pad_oen[0]}, 8'h01);
    db_limit = 4'd3;
    pad_c[1] = 1'b1;
    step(3);
    pad_c[1] = 1'b0;
    repeat (8) begin
      step(1);
      chk("glitch_di", {7'b0, core_di[1]}, 8'h00);
      chk("glitch_rise", {7'b0, rise_evt[1]}, 8'h00);
    end
    pad_c[1] = 1'b1;
    repeat (5) begin
      step(1);
      chk("db_wait", {7'b0, core_di[1]}, 8'h00);
    end
    step(1);
    chk("db_di", {7'b0, core_di[1]}, 8'h01);
    chk("db_rise", {7'b0, rise_evt[1]}, 8'h01);
    step(1);
    chk("db_rise_off", {7'b0, rise_evt[1]}, 8'h00);
    db_limit = 4'd0;
    for (int i = 0; i < 4; i++) begin
      logic nv;
      nv = !pad_c[2];
      pad_c[2] = nv;
      step(2);
      chk("byp_old", {7'b0, core_di[2]}, {7'b0, !nv});
      step(1);
      chk("byp_new", {7'b0, core_di[2]}, {7'b0, nv});
      chk("byp_rise", {7'b0, rise_evt[2]}, {7'b0, nv});
      chk("byp_fall", {7'b0, fall_evt[2]}, {7'b0, !nv});
      step(1);
    end
    pad_c = '0;
    step(6);
    int_en = 8'h01;
    pad_c[1:0] = 2'b11;
    step(3);
    chk("int_rise", rise_evt & 8'h03, 8'h03);
    step(1);
    chk("int_stat", int_stat, 8'h01);
    step(1);
    chk("int_irq", {7'b0, irq}, 8'h01);
    pad_c[0] = 1'b0;
    step(3);
    chk("int_fall", {7'b0, fall_evt[0]}, 8'h01);
    int_clr = 8'h01;
    step(1);
    int_clr = '0;
    chk("set_wins", int_stat, 8'h01);
    int_clr = 8'h01;
    step(1);
    int_clr = '0;
    chk("clr_stat", int_stat, 8'h00);
    step(1);
    chk("clr_irq", {7'b0, irq}, 8'h00);
    int_en = '0;
    db_limit = 4'hF;
    pad_c = '0;
    step(20);
    pad_c[3] = 1'b1;
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_di", {7'b0, core_di[3]}, 8'h00);
    step(17);
    chk("mid_wait", {7'b0, core_di[3]}, 8'h00);
    step(1);
    chk("mid_acc", {7'b0, core_di[3]}, 8'h01);
    chk("mid_rise", {7'b0, rise_evt[3]}, 8'h01);
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 8; n++) if ($urandom_range(0, 5) == 0) pad_c[n] = !pad_c[n];
      core_do = 8'($urandom);
      if ($urandom_range(0, 3) == 0) core_oe = 8'($urandom);
      if ($urandom_range(0, 40) == 0) db_limit = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 60) == 0) int_en = 8'($urandom);
      int_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rst = ($urandom_range(0, 300) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
